dec2bin: RTL and testbench

Sequential BCD-to-binary converter: takes a packed decimal number (one BCD digit per nibble, most significant digit in the top nibble) and produces its unsigned binary value over several clock cycles using a multiply-by-10-and-add accumulator. It is the inverse path of the binary-to-seven-segment display conversion. Game logic uses it to turn decimal values (keypad entry, decimal-stored scores) back into binary for arithmetic and comparison. The result is range-checked against the 13-bit binary width used throughout the display datapath. Invalid digits and out-of-range values are flagged.

---
 rtl/dec2bin.sv | 122 ++++++++++++
 tb/tb_dec2bin.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dec2bin.sv
// dec2bin: sequential packed-BCD to unsigned binary converter.
// Consumes one decimal digit per cycle, most significant first, using a
// multiply-by-10-and-add accumulator that saturates at 2^OUT_W-1.
module dec2bin #(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic [OUT_W-1:0]      bin,
  output logic                  err,
  output logic                  ovf
);

  localparam int AW = OUT_W + 4;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [AW-1:0] MAXV = {4'b0000, {OUT_W{1'b1}}};
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t              state, state_n;
  logic [4*DIGITS-1:0] opnd, opnd_n;
  logic [AW-1:0]       acc, acc_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic                serr, serr_n;
  logic                sovf, sovf_n;
  logic                done_n;
  logic [OUT_W-1:0]    bin_n;
  logic                err_n, ovf_n;
  logic [3:0]          digit;
  logic [AW-1:0]       prod;

  // Busy is a pure decode of the registered state.
  always_comb begin
    busy = (state == CONV);
  end

  // Next-state, accumulator step and result capture.
  always_comb begin
    state_n = state;
    opnd_n  = opnd;
    acc_n   = acc;
    cnt_n   = cnt;
    serr_n  = serr;
    sovf_n  = sovf;
    done_n  = 1'b0;
    bin_n   = bin;
    err_n   = err;
    ovf_n   = ovf;
    digit   = opnd[4*cnt +: 4];
    // acc never exceeds MAXV, so acc*10+9 fits in AW bits without wrapping
    prod    = (acc << 3) + (acc << 1) + AW'(digit);
    case (state)
      IDLE: begin
        if (start) begin
          opnd_n  = bcd;
          acc_n   = '0;
          serr_n  = 1'b0;
          sovf_n  = 1'b0;
          cnt_n   = LAST;
          state_n = CONV;
        end
      end
      CONV: begin
        if (digit > 4'd9) begin
          serr_n = 1'b1;
        end else if (sovf) begin
          acc_n = MAXV;
        end else if (prod > MAXV) begin
          sovf_n = 1'b1;
          acc_n  = MAXV;
        end else begin
          acc_n = prod;
        end
        cnt_n = cnt - 1'b1;
        // Result uses the sticky bits including the digit processed this edge
        if (cnt == '0) begin
          bin_n   = serr_n ? '0 : acc_n[OUT_W-1:0];
          err_n   = serr_n;
          ovf_n   = sovf_n & ~serr_n;
          done_n  = 1'b1;
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      opnd  <= '0;
      acc   <= '0;
      cnt   <= '0;
      serr  <= 1'b0;
      sovf  <= 1'b0;
      done  <= 1'b0;
      bin   <= '0;
      err   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      opnd  <= opnd_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      serr  <= serr_n;
      sovf  <= sovf_n;
      done  <= done_n;
      bin   <= bin_n;
      err   <= err_n;
      ovf   <= ovf_n;
    end
  end

endmodule

// File: tb/tb_dec2bin.sv
// tb_dec2bin: scoreboard bench for dec2bin with a decimal reference model.
module tb_dec2bin;

  localparam int DIGITS = 4;
  localparam int OUT_W  = 13;
  localparam int MAXV   = (1 << OUT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [15:0]       bcd = '0;
  logic              busy, done, err, ovf;
  logic [OUT_W-1:0]  bin;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          bin;
    logic        err;
    logic        ovf;
    int          cyc;
    logic [15:0] v;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   rem = 0;
  logic pend = 1'b0;
  logic [15:0] pend_v = '0;

  dec2bin #(.DIGITS(DIGITS), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .bcd(bcd),
    .busy(busy), .done(done), .bin(bin), .err(err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Decimal reference: sum digit*10^k, then apply range and error rules.
  function automatic exp_t model(input logic [15:0] v, input int c);
    exp_t r;
    int   val = 0;
    int   w = 1;
    logic e = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      int n;
      n = int'(v[4*i +: 4]);
      if (n > 9) e = 1'b1;
      val += n * w;
      w *= 10;
    end
    r.err = e;
    r.ovf = !e && (val > MAXV);
    r.bin = e ? 0 : ((val > MAXV) ? MAXV : val);
    r.cyc = c;
    r.v   = v;
    return r;
  endfunction

  // Acceptance decision sampled mid-cycle from the bench's own busy model.
  always @(negedge clk) begin
    pend   = !rst && start && (rem == 0);
    pend_v = bcd;
  end

  // Push expected results on accepting edges; reset discards pending work.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      rem = 0;
    end else if (pend) begin
      q.push_back(model(pend_v, cyc));
      rem = DIGITS;
    end else if (rem > 0) begin
      rem--;
    end
  end

  // Monitor: busy profile every cycle, result fields on each done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (busy !== (rem != 0)) begin
        failures++;
        $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, (rem != 0));
      end
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done cyc=%0d bin=%0d", cyc, bin);
        end else begin
          exp_t e;
          e = q.pop_front();
          checks += 4;
          if (int'(bin) != e.bin) begin
            failures++;
            $display("FAIL bin v=%h got=%0d want=%0d", e.v, bin, e.bin);
          end
          if (err !== e.err) begin
            failures++;
            $display("FAIL err v=%h got=%b want=%b", e.v, err, e.err);
          end
          if (ovf !== e.ovf) begin
            failures++;
            $display("FAIL ovf v=%h got=%b want=%b", e.v, ovf, e.ovf);
          end
          if (cyc - e.cyc != DIGITS) begin
            failures++;
            $display("FAIL latency v=%h got=%0d want=%0d", e.v, cyc - e.cyc, DIGITS);
          end
        end
      end else if (q.size() != 0 && (cyc - q[0].cyc) > DIGITS) begin
        checks++;
        failures++;
        $display("FAIL done_missing v=%h got=none want=done at latency %0d", q[0].v, DIGITS);
        void'(q.pop_front());
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(posedge clk); #1;
    while (rem != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (rem != 0) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout got=busy want=idle");
    end
  endtask

  task automatic issue(input logic [15:0] v);
    wait_idle();
    start = 1'b1;
    bcd   = v;
    @(posedge clk); #1;
    start = 1'b0;
    bcd   = 16'($urandom);
  endtask

  task automatic check_zero(input string tag);
    checks += 5;
    if (busy !== 1'b0) begin failures++; $display("FAIL %s_busy got=%b want=0", tag, busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL %s_done got=%b want=0", tag, done); end
    if (bin !== '0)    begin failures++; $display("FAIL %s_bin got=%0d want=0", tag, bin); end
    if (err !== 1'b0)  begin failures++; $display("FAIL %s_err got=%b want=0", tag, err); end
    if (ovf !== 1'b0)  begin failures++; $display("FAIL %s_ovf got=%b want=0", tag, ovf); end
  endtask

  initial begin
    logic [15:0] dir [8];
    dir = '{16'h1234, 16'h0000, 16'h8191, 16'h8192, 16'h9999,
            16'h12A4, 16'hF999, 16'h0500};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_zero("reset");

    foreach (dir[i]) issue(dir[i]);

    // Start re-asserted mid-conversion with a different operand is ignored.
    issue(16'h0042);
    @(posedge clk); #1;
    start = 1'b1;
    bcd   = 16'h0777;
    @(posedge clk); #1;
    start = 1'b0;

    // Start held high: second operand taken at the next idle cycle.
    wait_idle();
    start = 1'b1;
    bcd   = 16'h0001;
    begin
      int n = 0;
      do begin @(posedge clk); #1; n++; end while (rem != DIGITS && n < 20);
      bcd = 16'h0010;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (rem != DIGITS && n < 20);
      checks++;
      if (rem != DIGITS) begin
        failures++;
        $display("FAIL held_start got=no_accept want=accept");
      end
    end
    start = 1'b0;

    // Reset in the second cycle of a conversion aborts it silently.
    issue(16'h1234);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_zero("midreset");
    issue(16'h0500);

    // Randomised operands: mostly valid decimal, some arbitrary nibbles.
    for (int k = 0; k < 60; k++) begin
      logic [15:0] v;
      if ($urandom_range(0, 3) == 0) begin
        v = 16'($urandom);
      end else begin
        for (int d = 0; d < DIGITS; d++) v[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      issue(v);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    begin
      int n = 0;
      while (q.size() != 0 && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
    end
    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      failures++;
      $display("FAIL drain v=%h got=none want=done", e.v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
